// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: two per-source FIFOs serialized round-robin onto register-file write port 3.
// Optional WB_BYPASS_EN: an empty source that wins arbitration writes its input in the same cycle.
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_DEPTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_a_valid,
  output logic                  o_a_ready,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  output logic                  o_write_en_3,
  output logic [ADDR_WIDTH-1:0] o_addr_3,
  output logic [DATA_WIDTH-1:0] o_write_data_3,
  output logic [REG_DEPTH-1:0]  o_busy,
  output logic                  o_idle
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_t;

  wb_t [1:0] in_req, fifo_head, head;
  wb_t       sel;
  logic [1:0] in_vld, full, nempty, req, gnt, byp, push, pop;
  logic [1:0][REG_DEPTH-1:0] src_busy;
  logic       last_b;

  assign in_vld    = {i_b_valid, i_a_valid};
  assign in_req[0] = {i_a_addr, i_a_data};
  assign in_req[1] = {i_b_addr, i_b_data};

`ifdef WB_BYPASS_EN
  // An empty source presents its incoming request as if it were the head.
  assign req = nempty | in_vld;
  assign byp = gnt & ~nempty;
`else
  assign req = nempty;
  assign byp = '0;
`endif

  // last_b=1 means B won the most recent grant, so A wins the next tie.
  assign gnt[0] = req[0] & (~req[1] | last_b);
  assign gnt[1] = req[1] & (~req[0] | ~last_b);
  assign push   = in_vld & ~full & ~byp;
  assign pop    = gnt & nempty;

  for (genvar s = 0; s < 2; s++) begin : g_src
    wb_t                  mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr, rptr, off;
    logic [PW:0]          cnt;
    logic [REG_DEPTH-1:0] busy_l;

    assign nempty[s]    = cnt != '0;
    assign full[s]      = cnt == (PW+1)'(FIFO_DEPTH);
    assign fifo_head[s] = mem[rptr];
    assign head[s]      = byp[s] ? in_req[s] : fifo_head[s];
    assign src_busy[s]  = busy_l;

    always_ff @(posedge i_clk) begin
      if (i_arst) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[s]) begin
          mem[wptr] <= in_req[s];
          wptr      <= wptr + 1'b1;
        end
        if (pop[s]) rptr <= rptr + 1'b1;
        if (push[s] && !pop[s])      cnt <= cnt + 1'b1;
        else if (!push[s] && pop[s]) cnt <= cnt - 1'b1;
      end
    end

    // Slot i holds a live entry when its distance from the read pointer is below the count.
    always_comb begin
      busy_l = '0;
      off    = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        off = PW'(i) - rptr;
        if ({1'b0, off} < cnt && mem[i].addr != '0)
          busy_l = busy_l | ({{(REG_DEPTH-1){1'b0}}, 1'b1} << mem[i].addr);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst)    last_b <= 1'b1;
    else if (|gnt) last_b <= gnt[1];
  end

  assign sel            = gnt[1] ? head[1] : head[0];
  assign o_addr_3       = (|gnt) ? sel.addr : '0;
  assign o_write_data_3 = (|gnt) ? sel.data : '0;
  // x0 entries drain silently; nothing commits while reset is asserted.
  assign o_write_en_3   = (|gnt) && (sel.addr != '0) && !i_arst;
  assign o_a_ready      = ~full[0];
  assign o_b_ready      = ~full[1];
  assign o_busy         = src_busy[0] | src_busy[1];
  assign o_idle         = ~|nempty;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: per-source expected queues checked by a write-port monitor.
module tb_regfile_writeback_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [31:0]   busy;
  logic          idle;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] qa[$], qb[$];
  logic [AW-1:0]    got[$];

  always #5 clk = ~clk;

  regfile_writeback_arbiter dut (
    .i_clk(clk), .i_arst(arst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_write_en_3(we), .o_addr_3(waddr), .o_write_data_3(wdata),
    .o_busy(busy), .o_idle(idle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: B results carry 0xBB in the top data byte, everything else belongs to A.
  always @(negedge clk) begin : mon
    logic [AW+DW-1:0] e;
    if (!arst && we) begin
      got.push_back(waddr);
      if (wdata[63:56] == 8'hBB) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_b got addr %0d data %h", waddr, wdata);
        end else begin
          e = qb.pop_front();
          chk("wb_b_addr", 64'(waddr), 64'(e[AW+DW-1:DW]));
          chk("wb_b_data", wdata, e[DW-1:0]);
        end
      end else begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_a got addr %0d data %h", waddr, wdata);
        end else begin
          e = qa.pop_front();
          chk("wb_a_addr", 64'(waddr), 64'(e[AW+DW-1:DW]));
          chk("wb_a_data", wdata, e[DW-1:0]);
        end
      end
    end
  end

  task automatic push2(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       output logic aacc, output logic bacc);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    aacc = av && a_ready;
    bacc = bv && b_ready;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic reset_dut(input bit clr);
    arst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_we", we, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    if (clr) begin
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_ready", {a_ready, b_ready}, 2'b11);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !idle) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (n < 100), 1);
  endtask

  initial begin : stim
    logic aacc, bacc;
    reset_dut(1'b0);
`ifdef WB_BYPASS_EN
    // Idle block: A's request goes straight to the write port in the same cycle.
    qa.push_back({5'd7, 64'h1234});
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h1234;
    @(negedge clk);
    chk("byp_we", we, 1);
    chk("byp_addr", 64'(waddr), 7);
    chk("byp_busy", busy, 0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk("byp_idle", idle, 1);
    chk("byp_busy_after", busy, 0);
    drain();
`else
    // Single A write: visible the cycle after acceptance, busy until popped.
    qa.push_back({5'd5, 64'hDEAD});
    push2(1, 5'd5, 64'hDEAD, 0, '0, '0, aacc, bacc);
    chk("t1_acc", aacc, 1);
    @(negedge clk);
    chk("t1_we", we, 1);
    chk("t1_busy5", busy, 32'h20);
    chk("t1_idle_busy", idle, 0);
    @(negedge clk);
    chk("t1_busy_clr", busy, 0);
    chk("t1_idle", idle, 1);
    chk("t1_drained", qa.size(), 0);

    // Register queued twice stays busy until both entries pop.
    qa.push_back({5'd9, 64'h91});
    qa.push_back({5'd9, 64'h92});
    push2(1, 5'd9, 64'h91, 0, '0, '0, aacc, bacc);
    chk("t1b_busy9_first", busy, 32'h200);
    push2(1, 5'd9, 64'h92, 0, '0, '0, aacc, bacc);
    @(negedge clk);
    chk("t1b_busy9_second", busy, 32'h200);
    @(negedge clk);
    chk("t1b_busy9_clr", busy, 0);

    // Both sources every cycle: strict alternation, A first after reset.
    reset_dut(1'b0);
    got.delete();
    for (int k = 0; k < 4; k++) begin
      qa.push_back({5'(1 + k), 64'hA0 + 64'(k)});
      qb.push_back({5'(11 + k), 64'hBB00_0000_0000_00B0 + 64'(k)});
    end
    for (int k = 0; k < 4; k++) begin
      push2(1, 5'(1 + k), 64'hA0 + 64'(k), 1, 5'(11 + k), 64'hBB00_0000_0000_00B0 + 64'(k), aacc, bacc);
      chk("t2_acc", {aacc, bacc}, 2'b11);
    end
    drain();
    begin
      int exp_ord [8] = '{1, 11, 2, 12, 3, 13, 4, 14};
      chk("t2_count", got.size(), 8);
      for (int k = 0; k < 8 && k < got.size(); k++) chk("t2_order", 64'(got[k]), 64'(exp_ord[k]));
    end

    // Saturating both sources: B back-pressures, no loss, order preserved.
    reset_dut(1'b0);
    got.delete();
    for (int k = 0; k < 8; k++) begin
      qa.push_back({5'(1 + k), 64'hC0 + 64'(k)});
      qb.push_back({5'(16 + k), 64'hBB00_0000_0000_00D0 + 64'(k)});
    end
    begin
      int ia = 0, ib = 0, guard = 0;
      bit bstall = 0;
      while ((ia < 8 || ib < 8) && guard < 100) begin
        push2(ia < 8, 5'(1 + ia), 64'hC0 + 64'(ia),
              ib < 8, 5'(16 + ib), 64'hBB00_0000_0000_00D0 + 64'(ib), aacc, bacc);
        if (ib < 8 && !bacc) bstall = 1;
        if (aacc) ia++;
        if (bacc) ib++;
        guard++;
      end
      chk("t3_all_accepted", (guard < 100), 1);
      chk("t3_b_backpressure", bstall, 1);
    end
    drain();
    chk("t3_count", got.size(), 16);

    // x0: popped without a write enable and never busy.
    reset_dut(1'b0);
    push2(1, 5'd0, 64'hFF, 0, '0, '0, aacc, bacc);
    @(negedge clk);
    chk("t4_we", we, 0);
    chk("t4_busy", busy, 0);
    chk("t4_head_data", wdata, 64'hFF);
    chk("t4_not_idle", idle, 0);
    @(negedge clk);
    chk("t4_idle", idle, 1);
    chk("t4_busy_after", busy, 0);

    // Reset mid-flight drops queued entries and writes nothing afterwards.
    reset_dut(1'b0);
    for (int k = 0; k < 4; k++) begin
      qa.push_back({5'(1 + k), 64'hE0 + 64'(k)});
      qb.push_back({5'(20 + k), 64'hBB00_0000_0000_00F0 + 64'(k)});
    end
    for (int k = 0; k < 4; k++)
      push2(1, 5'(1 + k), 64'hE0 + 64'(k), 1, 5'(20 + k), 64'hBB00_0000_0000_00F0 + 64'(k), aacc, bacc);
    chk("t5_busy_before", (busy != 0), 1);
    reset_dut(1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t5_idle_hold", idle, 1);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
